tb_doutb_seq: RTL and testbench

- Command-driven sequencer for the TB read port and the TB_doutb mapping stage.
- Accepts one command at a time: operation, base address, length, l_k_0.
- Issues TB BRAM read enables and addresses.
- Drives TB_doutb_sel, l_k_0 and seq_cnt_dout_sel, delayed to line up with BRAM read latency.
- Flags when mapped B / B_cache data is valid, and pulses done at the end of each command.

---
 rtl/tb_doutb_pkg.sv | 47 ++++
 rtl/tb_doutb_dly.sv | 32 +++
 rtl/tb_doutb_seq.sv | 200 ++++++++++++++++++++
 tb/tb_tb_doutb_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_doutb_pkg.sv
// Shared encodings, step patterns and FSM states for the TB read-port / TB_doutb sequencer.
package tb_doutb_pkg;

  typedef enum logic [2:0] {
    DIR_IDLE          = 3'b000,
    DIR_POS           = 3'b001,
    DIR_NEG           = 3'b010,
    DIR_NEW           = 3'b011,
    B_CACHE_IDLE      = 3'b100,
    B_CACHE_TRANSFER  = 3'b101,
    B_CACHE_TRANSPOSE = 3'b110,
    B_CACHE_INV       = 3'b111
  } op_e;

  // Bit 2 of the op / TB_doutb_sel chooses between the B and B_cache mapping banks.
  localparam logic TB_doutb_B       = 1'b0;
  localparam logic TB_doutb_B_cache = 1'b1;

  localparam int INV_STEPS       = 8;
  localparam int TRANSPOSE_STEPS = 8;

  // Indexed by step number k (bit k set = active at step k).
  localparam logic [7:0] INV_VALID_MASK    = 8'b1110_0000;
  localparam logic [7:0] INV_RD_MASK       = 8'b0000_1110;
  localparam logic [7:0] TRANSPOSE_RD_MASK = 8'b1110_1110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  function automatic logic op_is_null(input logic [2:0] op);
    return op[1:0] == 2'b00;
  endfunction

  // Linear ops walk base+k for len steps; TRANSPOSE/INV use the fixed 8-step patterns.
  function automatic logic op_is_linear(input logic [2:0] op);
    return (op[2] == TB_doutb_B) || (op[1:0] == 2'b01);
  endfunction

  function automatic logic op_is_fixed(input logic [2:0] op);
    return (op[2] == TB_doutb_B_cache) && op[1];
  endfunction

endpackage

// File: rtl/tb_doutb_dly.sv
// Async-reset shift register used to line step information up with the TB BRAM read latency.
module tb_doutb_dly #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] stage_q;
  logic [DEPTH-1:0][W-1:0] stage_d;

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/tb_doutb_seq.sv
// Command-driven sequencer: issues TB BRAM reads and drives the latency-aligned TB_doutb mapping controls.
module tb_doutb_seq
  import tb_doutb_pkg::*;
#(
  parameter int TB_AW      = 10,
  parameter int LEN_DW     = 8,
  parameter int SEQ_CNT_DW = 5,
  parameter int TB_RD_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  sys_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic                  cmd_l_k_0,
  input  logic [TB_AW-1:0]      cmd_base,
  input  logic [LEN_DW-1:0]     cmd_len,
  output logic                  tb_en,
  output logic [TB_AW-1:0]      tb_addr,
  output logic [2:0]            TB_doutb_sel,
  output logic                  l_k_0,
  output logic [SEQ_CNT_DW-1:0] seq_cnt_dout_sel,
  output logic                  map_out_valid,
  output logic                  map_out_last,
  output logic                  done,
  output logic                  busy
);

  // Step record: {sel, l_k_0, seq_cnt, valid, last}
  localparam int REC_W   = 3 + 1 + SEQ_CNT_DW + 1 + 1;
  localparam int DRAIN_W = (TB_RD_LAT < 1) ? 1 : $clog2(TB_RD_LAT + 1);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic                l_k_0_q, l_k_0_d;
  logic [TB_AW-1:0]    base_q, base_d;
  logic [LEN_DW-1:0]   n_q, n_d;
  logic [LEN_DW-1:0]   k_q, k_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic                done_q, done_d;
  logic                tb_en_q, tb_en_d;
  logic [TB_AW-1:0]    tb_addr_q, tb_addr_d;
  logic [REC_W-1:0]    rec_q, rec_d;

  logic                  step_rd;
  logic                  step_valid;
  logic                  step_last;
  logic [TB_AW-1:0]      step_off;
  logic [SEQ_CNT_DW-1:0] step_seq;
  logic [1:0]            pair_idx;

  logic [REC_W-1:0]      rec_dly;
  logic [1:0]            map_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    l_k_0_d    = l_k_0_q;
    base_d     = base_q;
    n_d        = n_q;
    k_d        = k_q;
    drain_d    = drain_q;
    done_d     = 1'b0;
    tb_en_d    = 1'b0;
    tb_addr_d  = tb_addr_q;
    rec_d      = '0;
    step_rd    = 1'b0;
    step_valid = 1'b0;
    step_last  = 1'b0;
    step_off   = '0;
    step_seq   = '0;
    pair_idx   = 2'd0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          l_k_0_d = cmd_l_k_0;
          base_d  = cmd_base;
          k_d     = '0;
          drain_d = '0;
          if (op_is_null(cmd_op)) begin
            n_d = '0;
          end else if (op_is_fixed(cmd_op)) begin
            n_d = (cmd_op == B_CACHE_INV) ? LEN_DW'(INV_STEPS) : LEN_DW'(TRANSPOSE_STEPS);
          end else begin
            n_d = cmd_len;
          end
          state_d = (n_d == '0) ? ST_FIN : ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // TRANSPOSE reads base+0..2 twice (steps 1-3, 5-7); INV reads it once.
        pair_idx  = k_q[1:0] - 2'd1;
        step_last = (k_q == n_q - LEN_DW'(1));
        if (op_is_linear(op_q)) begin
          step_rd    = 1'b1;
          step_off   = TB_AW'(k_q);
          step_valid = 1'b1;
        end else begin
          step_off = TB_AW'(pair_idx);
          step_seq = SEQ_CNT_DW'(k_q);
          if (op_q == B_CACHE_INV) begin
            step_rd    = INV_RD_MASK[k_q[2:0]];
            step_valid = INV_VALID_MASK[k_q[2:0]];
          end else begin
            step_rd    = TRANSPOSE_RD_MASK[k_q[2:0]];
            step_valid = 1'b1;
          end
        end
        tb_en_d = step_rd;
        if (step_rd) begin
          tb_addr_d = base_q + step_off;
        end
        rec_d = {op_q, l_k_0_q, step_seq, step_valid, step_last};
        k_d   = k_q + LEN_DW'(1);
        if (step_last) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (drain_q == DRAIN_W'(TB_RD_LAT)) begin
          state_d = ST_FIN;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end

      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= DIR_IDLE;
      l_k_0_q   <= 1'b0;
      base_q    <= '0;
      n_q       <= '0;
      k_q       <= '0;
      drain_q   <= '0;
      done_q    <= 1'b0;
      tb_en_q   <= 1'b0;
      tb_addr_q <= '0;
      rec_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      l_k_0_q   <= l_k_0_d;
      base_q    <= base_d;
      n_q       <= n_d;
      k_q       <= k_d;
      drain_q   <= drain_d;
      done_q    <= done_d;
      tb_en_q   <= tb_en_d;
      tb_addr_q <= tb_addr_d;
      rec_q     <= rec_d;
    end
  end

  tb_doutb_dly #(
    .W     (REC_W),
    .DEPTH (TB_RD_LAT)
  ) u_dly_step (
    .clk   (clk),
    .rst_n (sys_rst_n),
    .d     (rec_q),
    .q     (rec_dly)
  );

  // The mapped output register lands one cycle after the select it was computed from.
  tb_doutb_dly #(
    .W     (2),
    .DEPTH (1)
  ) u_dly_map (
    .clk   (clk),
    .rst_n (sys_rst_n),
    .d     (rec_dly[1:0]),
    .q     (map_q)
  );

  assign cmd_ready        = (state_q == ST_IDLE);
  assign busy             = (state_q != ST_IDLE);
  assign done             = done_q;
  assign tb_en            = tb_en_q;
  assign tb_addr          = tb_addr_q;
  assign TB_doutb_sel     = rec_dly[REC_W-1 -: 3];
  assign l_k_0            = rec_dly[SEQ_CNT_DW+2];
  assign seq_cnt_dout_sel = rec_dly[SEQ_CNT_DW+1:2];
  assign map_out_valid    = map_q[1];
  assign map_out_last     = map_q[0];

endmodule

// File: tb/tb_tb_doutb_seq.sv
// Self-checking bench for tb_doutb_seq: table of commands, hand-written corner sequences, random commands vs. a cycle model.
module tb_tb_doutb_seq;

  localparam int TB_AW      = 10;
  localparam int LEN_DW     = 8;
  localparam int SEQ_CNT_DW = 5;
  localparam int TB_RD_LAT  = 1;

  logic                  clk = 1'b0;
  logic                  sys_rst_n;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic                  cmd_l_k_0;
  logic [TB_AW-1:0]      cmd_base;
  logic [LEN_DW-1:0]     cmd_len;
  logic                  tb_en;
  logic [TB_AW-1:0]      tb_addr;
  logic [2:0]            TB_doutb_sel;
  logic                  l_k_0;
  logic [SEQ_CNT_DW-1:0] seq_cnt_dout_sel;
  logic                  map_out_valid;
  logic                  map_out_last;
  logic                  done;
  logic                  busy;

  always #5 clk = ~clk;

  tb_doutb_seq #(
    .TB_AW      (TB_AW),
    .LEN_DW     (LEN_DW),
    .SEQ_CNT_DW (SEQ_CNT_DW),
    .TB_RD_LAT  (TB_RD_LAT)
  ) dut (
    .clk              (clk),
    .sys_rst_n        (sys_rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_l_k_0        (cmd_l_k_0),
    .cmd_base         (cmd_base),
    .cmd_len          (cmd_len),
    .tb_en            (tb_en),
    .tb_addr          (tb_addr),
    .TB_doutb_sel     (TB_doutb_sel),
    .l_k_0            (l_k_0),
    .seq_cnt_dout_sel (seq_cnt_dout_sel),
    .map_out_valid    (map_out_valid),
    .map_out_last     (map_out_last),
    .done             (done),
    .busy             (busy)
  );

  typedef struct packed {
    logic [2:0]        op;
    logic              lk;
    logic [TB_AW-1:0]  base;
    logic [LEN_DW-1:0] len;
  } cmd_t;

  typedef struct {
    string name;
    cmd_t  c;
    int    exp_reads;
    int    exp_valids;
    int    exp_done;
  } vec_t;

  int total = 0;
  int bad = 0;
  int addr_model = 0;
  int cnt_rd;
  int cnt_mv;
  int done_at;

  function automatic int steps_of(cmd_t c);
    if (c.op[1:0] == 2'b00) return 0;
    if (c.op == 3'b110 || c.op == 3'b111) return 8;
    return int'(c.len);
  endfunction

  function automatic bit is_fixed(cmd_t c);
    return c.op == 3'b110 || c.op == 3'b111;
  endfunction

  function automatic bit is_read(cmd_t c, int k);
    if (c.op == 3'b110) return (k % 4) != 0;
    if (c.op == 3'b111) return (k >= 1) && (k <= 3);
    return 1'b1;
  endfunction

  function automatic int read_off(cmd_t c, int k);
    if (is_fixed(c)) return (k % 4) - 1;
    return k;
  endfunction

  function automatic bit is_valid(cmd_t c, int k);
    if (c.op == 3'b111) return k >= 5;
    return 1'b1;
  endfunction

  task automatic checkOutput(input string what, input int at, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0d: got %0d, want %0d", what, at, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag, input int at);
    checkOutput({tag, ".tb_en"}, at, tb_en, 0);
    checkOutput({tag, ".tb_addr"}, at, tb_addr, 0);
    checkOutput({tag, ".sel"}, at, TB_doutb_sel, 0);
    checkOutput({tag, ".l_k_0"}, at, l_k_0, 0);
    checkOutput({tag, ".seq"}, at, seq_cnt_dout_sel, 0);
    checkOutput({tag, ".map_valid"}, at, map_out_valid, 0);
    checkOutput({tag, ".map_last"}, at, map_out_last, 0);
    checkOutput({tag, ".done"}, at, done, 0);
    checkOutput({tag, ".busy"}, at, busy, 0);
    checkOutput({tag, ".cmd_ready"}, at, cmd_ready, 1);
  endtask

  // Walks one command's cycles (r=0 is the cycle after the accepting edge) against the timing rules.
  task automatic checkTrace(input cmd_t c, input int max_r);
    int n;
    int done_r;
    int last_r;
    int k;
    bit e_en;
    bit e_mv;
    bit e_ml;
    int e_sel;
    int e_lk;
    int e_seq;
    n = steps_of(c);
    done_r = (n == 0) ? 1 : n + TB_RD_LAT + 2;
    last_r = (max_r < done_r) ? max_r : done_r;
    cnt_rd = 0;
    cnt_mv = 0;
    done_at = -1;
    for (int r = 0; r <= last_r; r++) begin
      @(negedge clk);
      e_en = 1'b0;
      e_mv = 1'b0;
      e_ml = 1'b0;
      e_sel = 0;
      e_lk = 0;
      e_seq = 0;
      k = r - 1;
      if (k >= 0 && k < n && is_read(c, k)) begin
        e_en = 1'b1;
        addr_model = (int'(c.base) + read_off(c, k)) % (1 << TB_AW);
      end
      k = r - 1 - TB_RD_LAT;
      if (k >= 0 && k < n) begin
        e_sel = int'(c.op);
        e_lk = int'(c.lk);
        e_seq = is_fixed(c) ? k : 0;
      end
      k = r - 2 - TB_RD_LAT;
      if (k >= 0 && k < n && is_valid(c, k)) begin
        e_mv = 1'b1;
        e_ml = (k == n - 1);
      end
      checkOutput("tb_en", r, tb_en, e_en);
      checkOutput("tb_addr", r, tb_addr, addr_model);
      checkOutput("TB_doutb_sel", r, TB_doutb_sel, e_sel);
      checkOutput("l_k_0", r, l_k_0, e_lk);
      checkOutput("seq_cnt", r, seq_cnt_dout_sel, e_seq);
      checkOutput("map_out_valid", r, map_out_valid, e_mv);
      checkOutput("map_out_last", r, map_out_last, e_ml);
      checkOutput("done", r, done, (r == done_r));
      checkOutput("busy", r, busy, (r < done_r));
      checkOutput("cmd_ready", r, cmd_ready, (r >= done_r));
      if (tb_en) cnt_rd++;
      if (map_out_valid) cnt_mv++;
      if (done && done_at < 0) done_at = r;
    end
  endtask

  task automatic applyStimulus(input cmd_t c, input bit hold, input int max_r);
    @(negedge clk);
    checkOutput("ready_before_cmd", -1, cmd_ready, 1);
    cmd_op = c.op;
    cmd_l_k_0 = c.lk;
    cmd_base = c.base;
    cmd_len = c.len;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    checkTrace(c, max_r);
  endtask

  vec_t vecs[9];

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog at %0t: got timeout, want finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cmd_t hc;
    vecs[0] = '{"pos_b5_l3",      '{3'b001, 1'b0, 10'd5,    8'd3},  3, 3, 6};
    vecs[1] = '{"transpose_b16",  '{3'b110, 1'b0, 10'd16,   8'd3},  6, 8, 11};
    vecs[2] = '{"inv_b32",        '{3'b111, 1'b0, 10'd32,   8'd50}, 3, 3, 11};
    vecs[3] = '{"dir_idle",       '{3'b000, 1'b1, 10'd9,    8'd5},  0, 0, 1};
    vecs[4] = '{"new_len0",       '{3'b011, 1'b1, 10'd40,   8'd0},  0, 0, 1};
    vecs[5] = '{"transfer_b100",  '{3'b101, 1'b1, 10'd100,  8'd4},  4, 4, 7};
    vecs[6] = '{"bcache_idle",    '{3'b100, 1'b0, 10'd3,    8'd7},  0, 0, 1};
    vecs[7] = '{"transpose_wrap", '{3'b110, 1'b1, 10'd1022, 8'd0},  6, 8, 11};
    vecs[8] = '{"new_l1_b500",    '{3'b011, 1'b1, 10'd500,  8'd1},  1, 1, 4};

    sys_rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'b000;
    cmd_l_k_0 = 1'b0;
    cmd_base = '0;
    cmd_len = '0;
    #12;
    check_all_zero("reset", 0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    addr_model = 0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].c, 1'b0, 1000);
      checkOutput({vecs[i].name, ".reads"}, i, cnt_rd, vecs[i].exp_reads);
      checkOutput({vecs[i].name, ".valids"}, i, cnt_mv, vecs[i].exp_valids);
      checkOutput({vecs[i].name, ".done_at"}, i, done_at, vecs[i].exp_done);
    end

    // NEG with cmd_valid held: re-accepted right after done, addresses wrap 1023 -> 0
    hc = '{3'b010, 1'b0, 10'd1023, 8'd2};
    applyStimulus(hc, 1'b1, 1000);
    checkOutput("held1.reads", 0, cnt_rd, 2);
    checkOutput("held1.done_at", 0, done_at, 5);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checkTrace(hc, 1000);
    checkOutput("held2.reads", 1, cnt_rd, 2);
    checkOutput("held2.addr_end", 1, tb_addr, 0);

    // Reset during step 4 of TRANSPOSE aborts without done
    hc = '{3'b110, 1'b0, 10'd16, 8'd0};
    applyStimulus(hc, 1'b0, 4);
    @(posedge clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("abort", 0);
    addr_model = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort.done", i, done, 0);
    end
    @(negedge clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_all_zero("post_abort", i);
    end
    hc = '{3'b001, 1'b0, 10'd200, 8'd1};
    applyStimulus(hc, 1'b0, 1000);
    checkOutput("post_abort.done_at", 0, done_at, 4);
    checkOutput("post_abort.reads", 0, cnt_rd, 1);

    for (int i = 0; i < 30; i++) begin
      cmd_t rc;
      rc.op = 3'($urandom_range(0, 7));
      rc.lk = 1'($urandom_range(0, 1));
      rc.base = TB_AW'($urandom_range(0, (1 << TB_AW) - 1));
      rc.len = LEN_DW'($urandom_range(0, 12));
      applyStimulus(rc, 1'b0, 1000);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
